ram_arbiter: RTL and testbench

Shares the processor's single-port 4096x4 data RAM between the CPU datapath and a DMA/loader port. Registers one command per cycle from the winning requester, drives the RAM, and returns read data with a fixed latency. The CPU has priority, bounded by an anti-starvation counter that guarantees the DMA port service. It sits between the CPU's RAM address/data path (`{oprnd, program_byte}` address, 4-bit data bus) and the RAM macro.

---
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port 4096x4 synchronous RAM between the CPU
// datapath and a DMA/loader port. The capture stage registers one command
// per cycle onto the RAM pins. The return stage routes the read data back to
// whichever requester issued the read. CPU has priority. A starvation
// counter hands contention to DMA once it has lost MAX_WAIT times.
module ram_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [3:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [3:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [11:0] dma_addr,
  input  logic [3:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [3:0]  dma_rdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [3:0]  ram_wdata,
  input  logic [3:0]  ram_rdata,
  output logic [7:0]  dma_wait_cnt
);

  logic cpu_elig, dma_elig;
  logic cpu_win, dma_win;
  logic rd_pend;   // a read was on the RAM pins last cycle
  logic rd_dma;    // ...and it belongs to the DMA port

  // A requester sitting in its gnt cycle still shows req (it must hold the
  // command through gnt), so it is masked out to avoid a double issue.
  assign cpu_elig = cpu_req & ~cpu_gnt;
  assign dma_elig = dma_req & ~dma_gnt;

  assign dma_win = dma_elig & (~cpu_elig | (dma_wait_cnt >= 8'(MAX_WAIT)));
  assign cpu_win = cpu_elig & ~dma_win;

  // Capture stage: register the winner's command onto the RAM pins.
  // Address and write data hold through idle cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      cpu_gnt <= cpu_win;
      dma_gnt <= dma_win;
      ram_cs  <= cpu_win | dma_win;
      if (dma_win) begin
        ram_we    <= dma_we;
        ram_addr  <= dma_addr;
        ram_wdata <= dma_wdata;
      end else if (cpu_win) begin
        ram_we    <= cpu_we;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

  // Starvation counter: clears when DMA is served, counts its lost contentions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      dma_wait_cnt <= '0;
    else if (dma_win)
      dma_wait_cnt <= '0;
    else if (dma_elig && dma_wait_cnt != 8'hFF)
      dma_wait_cnt <= dma_wait_cnt + 8'd1;
  end

  // Return stage: tag the read on the RAM pins, then steer the RAM output
  // to the tagged requester one cycle later. Reset drops any tag in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pend    <= 1'b0;
      rd_dma     <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      rd_pend    <= ram_cs & ~ram_we;
      rd_dma     <= dma_gnt;
      cpu_rvalid <= rd_pend & ~rd_dma;
      dma_rvalid <= rd_pend & rd_dma;
      if (rd_pend && !rd_dma) cpu_rdata <= ram_rdata;
      if (rd_pend && rd_dma)  dma_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed accesses push expected grants and read
// data into queues; a negedge monitor pops and compares whenever the DUT
// presents a gnt or rvalid. A second instance with MAX_WAIT=2 exercises the
// starvation path with CPU eligibility held on.
`timescale 1ns/1ps
module tb_ram_arbiter;

  typedef struct packed {
    logic        dma;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  wdata;
  } cmd_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [11:0] cpu_addr = 0, dma_addr = 0;
  logic [3:0]  cpu_wdata = 0, dma_wdata = 0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_cs, ram_we;
  logic [3:0]  cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic [11:0] ram_addr;
  logic [7:0]  dma_wait_cnt;

  // second instance, starvation only
  logic        d2_dma_req = 0;
  logic        d2_cpu_gnt, d2_cpu_rvalid, d2_dma_gnt, d2_dma_rvalid;
  logic        d2_ram_cs, d2_ram_we;
  logic [3:0]  d2_cpu_rdata, d2_dma_rdata, d2_ram_wdata;
  logic [11:0] d2_ram_addr;
  logic [7:0]  d2_wait_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  cmd_t gnt_q[$];
  logic [3:0] cpu_rd_q[$], dma_rd_q[$];
  int   cpu_lat_q[$], dma_lat_q[$];
  cmd_t mon_cmd;
  logic [3:0] mem [4096];

  always #5 clock = ~clock;

  ram_arbiter #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dma_wait_cnt(dma_wait_cnt)
  );

  ram_arbiter #(.MAX_WAIT(2)) dut2 (
    .clock(clock), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(12'h000), .cpu_wdata(4'h0),
    .cpu_gnt(d2_cpu_gnt), .cpu_rvalid(d2_cpu_rvalid), .cpu_rdata(d2_cpu_rdata),
    .dma_req(d2_dma_req), .dma_we(1'b1), .dma_addr(12'h0AA), .dma_wdata(4'h5),
    .dma_gnt(d2_dma_gnt), .dma_rvalid(d2_dma_rvalid), .dma_rdata(d2_dma_rdata),
    .ram_cs(d2_ram_cs), .ram_we(d2_ram_we), .ram_addr(d2_ram_addr), .ram_wdata(d2_ram_wdata),
    .ram_rdata(4'h0), .dma_wait_cnt(d2_wait_cnt)
  );

  // synchronous single-port RAM model
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every gnt must match the next expected command, every rvalid
  // the next expected data exactly two cycles after its read gnt.
  always @(negedge clock) begin
    if (!reset) begin
      cpu_lat_q.delete();
      dma_lat_q.delete();
    end else begin
      if (cpu_gnt || dma_gnt) begin
        chk("gnt_onehot", {31'd0, cpu_gnt & dma_gnt}, 0);
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", 1, 0);
        end else begin
          mon_cmd = gnt_q.pop_front();
          chk("gnt_who", {31'd0, dma_gnt}, {31'd0, mon_cmd.dma});
          chk("gnt_ram_cs", {31'd0, ram_cs}, 1);
          chk("gnt_ram_we", {31'd0, ram_we}, {31'd0, mon_cmd.we});
          chk("gnt_ram_addr", {20'd0, ram_addr}, {20'd0, mon_cmd.addr});
          chk("gnt_ram_wdata", {28'd0, ram_wdata}, {28'd0, mon_cmd.wdata});
          if (!mon_cmd.we) begin
            if (mon_cmd.dma) dma_lat_q.push_back(cyc + 2);
            else             cpu_lat_q.push_back(cyc + 2);
          end
        end
      end else begin
        chk("idle_ram_cs", {31'd0, ram_cs}, 0);
      end
      chk("rvalid_onehot", {31'd0, cpu_rvalid & dma_rvalid}, 0);
      if (cpu_rvalid) begin
        if (cpu_rd_q.size() == 0 || cpu_lat_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
        else begin
          chk("cpu_rdata", {28'd0, cpu_rdata}, {28'd0, cpu_rd_q.pop_front()});
          chk("cpu_rvalid_lat", cyc, cpu_lat_q.pop_front());
        end
      end
      if (dma_rvalid) begin
        if (dma_rd_q.size() == 0 || dma_lat_q.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
        else begin
          chk("dma_rdata", {28'd0, dma_rdata}, {28'd0, dma_rd_q.pop_front()});
          chk("dma_rvalid_lat", cyc, dma_lat_q.pop_front());
        end
      end
    end
  end

  // One access on either port; called and returns at posedge+1.
  task automatic access(input bit is_dma, input logic we, input logic [11:0] a,
                        input logic [3:0] d, input logic [3:0] exp_rd, input int exp_lat);
    int n;
    logic g;
    gnt_q.push_back('{is_dma, we, a, d});
    if (!we) begin
      if (is_dma) dma_rd_q.push_back(exp_rd);
      else        cpu_rd_q.push_back(exp_rd);
    end
    if (is_dma) begin dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1; end
    else        begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      g = is_dma ? dma_gnt : cpu_gnt;
    end while (!g && n < 20);
    chk(is_dma ? "dma_gnt_seen" : "cpu_gnt_seen", {31'd0, g}, 1);
    if (exp_lat > 0) chk(is_dma ? "dma_gnt_lat" : "cpu_gnt_lat", n, exp_lat);
    @(posedge clock); #1;
    if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnts"},   {30'd0, cpu_gnt, dma_gnt}, 0);
    chk({tag, "_rvalid"}, {30'd0, cpu_rvalid, dma_rvalid}, 0);
    chk({tag, "_ram_cs"}, {30'd0, ram_cs, ram_we}, 0);
    chk({tag, "_ram_addr"}, {20'd0, ram_addr}, 0);
    chk({tag, "_ram_wdata"}, {28'd0, ram_wdata}, 0);
    chk({tag, "_rdata"}, {24'd0, cpu_rdata, dma_rdata}, 0);
    chk({tag, "_wait_cnt"}, {24'd0, dma_wait_cnt}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset = 1'b0;
    #2 chk_all_zero("por");
    @(negedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;

    // CPU write then read-back of the same address
    access(0, 1'b1, 12'h05F, 4'hA, 4'h0, 1);
    access(0, 1'b0, 12'h05F, 4'h0, 4'hA, 1);
    repeat (3) @(posedge clock); #1;

    // reset pulsed during an outstanding read: no rvalid may follow
    gnt_q.push_back('{1'b0, 1'b0, 12'h123, 4'h0});
    cpu_we = 0; cpu_addr = 12'h123; cpu_wdata = 0; cpu_req = 1'b1;
    @(posedge clock); #1;
    chk("rst_rd_gnt", {31'd0, cpu_gnt}, 1);
    @(negedge clock); #1;
    reset = 1'b0; cpu_req = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clock); #1 chk("rst_hold_cs", {31'd0, ram_cs}, 0);
    @(negedge clock); #1 chk("rst_hold_cs2", {31'd0, ram_cs}, 0);
    reset = 1'b1;
    repeat (5) @(posedge clock); #1;
    chk("rst_no_rvalid_rdata", {28'd0, cpu_rdata}, 0);

    // contention: grants alternate, DMA never waits more than one edge
    for (int k = 0; k < 3; k++) begin
      gnt_q.push_back('{1'b0, 1'b1, 12'h100, 4'h1});
      gnt_q.push_back('{1'b1, 1'b1, 12'h200, 4'h2});
    end
    cpu_we = 1; cpu_addr = 12'h100; cpu_wdata = 4'h1;
    dma_we = 1; dma_addr = 12'h200; dma_wdata = 4'h2;
    cpu_req = 1; dma_req = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (k == 0) chk("cont_cnt_first", {24'd0, dma_wait_cnt}, 1);
      chk("cont_cnt_le1", {31'd0, dma_wait_cnt <= 8'd1}, 1);
    end
    cpu_req = 0; dma_req = 0;
    repeat (2) @(posedge clock); #1;

    // seed RAM then interleaved reads, DMA first, CPU one cycle later
    access(1, 1'b1, 12'hFFF, 4'h3, 4'h0, 1);
    access(0, 1'b1, 12'h000, 4'hC, 4'h0, 1);
    fork
      access(1, 1'b0, 12'hFFF, 4'h0, 4'h3, 1);
      begin @(posedge clock); #1; access(0, 1'b0, 12'h000, 4'h0, 4'hC, 1); end
    join
    repeat (3) @(posedge clock); #1;
    chk("inter_cpu_hold", {28'd0, cpu_rdata}, 4'hC);
    chk("inter_dma_hold", {28'd0, dma_rdata}, 4'h3);

    // top address write, then idle: address/data held, cs and we low
    access(1, 1'b1, 12'hFFF, 4'h7, 4'h0, 1);
    chk("idle_cs", {30'd0, ram_cs, ram_we}, 0);
    chk("idle_addr", {20'd0, ram_addr}, 12'hFFF);
    chk("idle_wdata", {28'd0, ram_wdata}, 4'h7);
    @(posedge clock); #1;
    chk("idle_addr2", {20'd0, ram_addr}, 12'hFFF);
    access(0, 1'b0, 12'hFFF, 4'h0, 4'h7, 1);
    repeat (3) @(posedge clock); #1;

    // starvation, MAX_WAIT=2, CPU held eligible every edge
    force dut2.cpu_elig = 1'b1;
    d2_dma_req = 1'b1;
    @(posedge clock); #1;
    chk("starv_cnt1", {24'd0, d2_wait_cnt}, 1);
    chk("starv_gnt1", {30'd0, d2_cpu_gnt, d2_dma_gnt}, 2'b10);
    @(posedge clock); #1;
    chk("starv_cnt2", {24'd0, d2_wait_cnt}, 2);
    chk("starv_gnt2", {30'd0, d2_cpu_gnt, d2_dma_gnt}, 2'b10);
    @(posedge clock); #1;
    chk("starv_dma_win", {30'd0, d2_cpu_gnt, d2_dma_gnt}, 2'b01);
    chk("starv_cnt_clr", {24'd0, d2_wait_cnt}, 0);
    d2_dma_req = 1'b0;
    release dut2.cpu_elig;
    repeat (2) @(posedge clock); #1;

    chk("gnt_q_drained", gnt_q.size(), 0);
    chk("cpu_rd_q_drained", cpu_rd_q.size(), 0);
    chk("dma_rd_q_drained", dma_rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
